if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline; sits directly upstream of the ID-stage Control decoder.
- Holds the PC and drives the instruction-memory address; latches the fetched word into IF/ID.
- Applies redirects from ID (j/jal/jr/jalr, via Control's PCSrc) and from EX (taken branches), plus hazard stalls and flushes.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble word loaded into IF/ID on flush or reset (sll $0,$0,0).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- Instruction  in  32  instruction-memory read data for InstAddr; combinational, same cycle.
- Stall  in  1  load-use hazard; hold PC and IF/ID.
- PCSrc  in  2  from Control on ID_Instruction: 00 sequential, 01 j/jal, 10 jr/jalr, 11 treated as 00.
- JrTarget  in  32  forwarded rs value for jr/jalr.
- BranchTaken  in  1  EX-stage branch resolved taken.
- BranchTarget  in  32  EX-stage branch target.
- InstAddr  out  32  current PC to instruction memory.
- ID_Instruction  out  32  IF/ID instruction (feeds OpCode/Funct/rs/rt/rd/imm).
- ID_PC_plus4  out  32  IF/ID PC+4.
- ID_LinkAddr  out  32  return address for jal/jalr writeback.
- ID_Valid  out  1  IF/ID holds a real instruction.
- ID_EX_Flush  out  1  bubble request to the downstream ID/EX register.

Behaviour:
- Reset (sync, active-high) sets: PC=RESET_PC, ID_Instruction=NOP_INSTR, ID_PC_plus4=RESET_PC, ID_Valid=0. InstAddr follows PC, so it equals RESET_PC. ID_EX_Flush is combinational and carries no reset value.
- Reset asserted mid-operation overrides every other input on that edge. Fetch resumes at RESET_PC on the first cycle after deassertion.
- InstAddr = PC. Instruction is consumed in the same cycle, so IF-to-ID latency is 1 cycle.
- JumpTarget = {ID_PC_plus4[31:28], ID_Instruction[25:0], 2'b00}.
- ID redirect is active only when ID_Valid=1 (PCSrc from a bubble is ignored).
- Next-PC priority, highest first:
  1. BranchTaken: PC<=BranchTarget; IF/ID<=NOP, Valid=0. Overrides Stall, because the stalled ID instruction is wrong-path.
  2. Stall: PC and IF/ID hold. A pending jump stays in ID and re-evaluates next cycle.
  3. PCSrc=01: PC<=JumpTarget; IF/ID<=NOP/Valid=0 (see Optional Feature).
  4. PCSrc=10: PC<=JrTarget; IF/ID<=NOP/Valid=0 (see Optional Feature).
  5. Otherwise: PC<=PC+4; IF/ID<={Instruction, PC+4}, Valid=1.
- PC+4 is modulo-2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000. PC[1:0] is not checked; targets pass through unmodified.
- ID_EX_Flush = BranchTaken (combinational), unless modified by the Optional Feature.
- ID_LinkAddr = ID_PC_plus4, unless modified by the Optional Feature.
- Simultaneous BranchTaken and ID jump: the branch wins and the jump is flushed.
- Simultaneous Stall and ID jump: the jump is deferred, not lost.

Optional Feature:
- Macro: DELAY_SLOT_EN.
- Defined (MIPS delay-slot semantics):
  - ID jump: IF/ID loads the fetched Instruction (the delay slot), Valid=1, and PC<=target.
  - BranchTaken: ID_EX_Flush=0, because the ID instruction is the branch's delay slot. IF/ID is still flushed.
  - ID_LinkAddr = ID_PC_plus4 + 4.
- Undefined: no delay slot; behaviour exactly as in Behaviour above.

Decomposition:
- Package mips_pkg holds:
  - PCSRC_SEQ=2'b00, PCSRC_JUMP=2'b01, PCSRC_JR=2'b10.
  - NOP_INSTR and default RESET_PC.
  - INST_W=32.
- One sub-module: if_id_reg. It contains the IF/ID register, with load/hold/flush controls and reset to NOP. It is reused as a template for ID/EX.

Test Plan:
- Reset, then 3 cycles with no stalls or redirects -> InstAddr 0,4,8,C; ID_Instruction lags Instruction by 1 cycle; ID_Valid rises on cycle 2.
- ID holds j 0x0000100 (PCSrc=01) with ID_PC_plus4=0x0000_0014 -> next InstAddr=0x0000_0400; ID_Instruction=NOP, ID_Valid=0. With DELAY_SLOT_EN, IF/ID instead holds the word fetched at 0x14 and ID_LinkAddr=0x18.
- Stall=1 for 2 cycles while ID holds jr (PCSrc=10, JrTarget=0x80) -> PC and IF/ID frozen for 2 cycles, then InstAddr=0x80.
- BranchTaken=1, BranchTarget=0x200, asserted together with Stall=1 and PCSrc=01 -> InstAddr=0x200; IF/ID=NOP; ID_EX_Flush=1 (0 with DELAY_SLOT_EN).
- PC=0xFFFF_FFFC with no redirect -> next InstAddr=0x0000_0000.
- reset asserted mid-run with PC=0x40 and ID_Valid=1 -> on the next edge PC=RESET_PC and ID_Valid=0; fetch resumes from RESET_PC after deassertion.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end.
//
// Contents:
//   INST_W           - instruction / address width
//   PCSRC_*          - encodings of Control's PCSrc field
//   NOP_INSTR        - bubble word (sll $0,$0,0)
//   DEFAULT_RESET_PC - default PC loaded on reset
//   if_id_t          - payload carried by the IF/ID pipeline register
package mips_pkg;

  localparam int INST_W = 32;

  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_JUMP = 2'b01;
  localparam logic [1:0] PCSRC_JR   = 2'b10;

  localparam logic [INST_W-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [INST_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic              valid;
    logic [INST_W-1:0] pcPlus4;
    logic [INST_W-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register with synchronous reset, flush and load controls.
// Used for IF/ID here and meant as the template for ID/EX.
//
// Ports:
//   clk     - rising-edge clock
//   reset   - synchronous active-high reset, loads RESET_VAL
//   load_i  - capture data_i on the next edge
//   flush_i - load FLUSH_VAL (bubble) on the next edge, beats load_i
//   data_i  - payload to capture
//   data_o  - registered payload
// With neither load_i nor flush_i asserted the register holds (stall).
module if_id_reg #(
  parameter int           W         = 65,
  parameter logic [W-1:0] RESET_VAL = '0,
  parameter logic [W-1:0] FLUSH_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         flush_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= RESET_VAL;
    end else if (flush_i) begin
      data_q <= FLUSH_VAL;
    end else if (load_i) begin
      data_q <= data_i;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS
// pipeline. Holds the PC, drives the instruction-memory address and latches
// the fetched word into IF/ID. Applies EX branch redirects, ID jump redirects,
// load-use stalls and flushes.
//
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   Instruction     - instruction-memory data for InstAddr (same cycle)
//   Stall           - hold PC and IF/ID
//   PCSrc           - Control's redirect select for the ID instruction
//   JrTarget        - forwarded rs for jr/jalr
//   BranchTaken     - EX branch resolved taken
//   BranchTarget    - EX branch target
//   InstAddr        - current PC
//   ID_Instruction  - IF/ID instruction word
//   ID_PC_plus4     - IF/ID PC+4
//   ID_LinkAddr     - return address for jal/jalr
//   ID_Valid        - IF/ID holds a real instruction
//   ID_EX_Flush     - bubble request to ID/EX
//
// Build option: define DELAY_SLOT_EN for MIPS branch/jump delay-slot
// semantics (jump keeps the fetched slot, branch does not kill ID,
// link address skips the slot).
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = mips_pkg::DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INST_W-1:0] Instruction,
  input  logic              Stall,
  input  logic [1:0]        PCSrc,
  input  logic [INST_W-1:0] JrTarget,
  input  logic              BranchTaken,
  input  logic [INST_W-1:0] BranchTarget,
  output logic [INST_W-1:0] InstAddr,
  output logic [INST_W-1:0] ID_Instruction,
  output logic [INST_W-1:0] ID_PC_plus4,
  output logic [INST_W-1:0] ID_LinkAddr,
  output logic              ID_Valid,
  output logic              ID_EX_Flush
);

  localparam if_id_t IF_ID_BUBBLE = '{valid: 1'b0, pcPlus4: RESET_PC, instr: NOP_INSTR};

  logic [INST_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] pcPlus4;
  logic [INST_W-1:0] jumpTarget;
  logic              ifIdLoad;
  logic              ifIdFlush;
  if_id_t            ifIdIn;
  if_id_t            ifIdOut;

  assign pcPlus4    = pc_q + 32'd4;
  assign jumpTarget = {ifIdOut.pcPlus4[31:28], ifIdOut.instr[25:0], 2'b00};

  // Next-PC selection. A taken branch beats a stall because the stalled ID
  // instruction is on the wrong path. ID redirects are only honoured for a
  // valid IF/ID entry so a bubble's decoded PCSrc is ignored. A stalled jump
  // simply stays in ID and is re-evaluated next cycle.
  always_comb begin
    pc_d      = pc_q;
    ifIdLoad  = 1'b0;
    ifIdFlush = 1'b0;
    if (BranchTaken) begin
      pc_d      = BranchTarget;
      ifIdFlush = 1'b1;
    end else if (Stall) begin
      pc_d = pc_q;
    end else if (ifIdOut.valid && (PCSrc == PCSRC_JUMP || PCSrc == PCSRC_JR)) begin
      pc_d = (PCSrc == PCSRC_JUMP) ? jumpTarget : JrTarget;
`ifdef DELAY_SLOT_EN
      // The word fetched this cycle is the delay slot and must execute.
      ifIdLoad  = 1'b1;
`else
      ifIdFlush = 1'b1;
`endif
    end else begin
      pc_d     = pcPlus4;
      ifIdLoad = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign ifIdIn = '{valid: 1'b1, pcPlus4: pcPlus4, instr: Instruction};

  if_id_reg #(
    .W        ($bits(if_id_t)),
    .RESET_VAL(IF_ID_BUBBLE),
    .FLUSH_VAL(IF_ID_BUBBLE)
  ) u_if_id_reg (
    .clk    (clk),
    .reset  (reset),
    .load_i (ifIdLoad),
    .flush_i(ifIdFlush),
    .data_i (ifIdIn),
    .data_o (ifIdOut)
  );

  assign InstAddr       = pc_q;
  assign ID_Instruction = ifIdOut.instr;
  assign ID_PC_plus4    = ifIdOut.pcPlus4;
  assign ID_Valid       = ifIdOut.valid;

`ifdef DELAY_SLOT_EN
  // The ID instruction is the branch's delay slot, so it must survive.
  assign ID_EX_Flush = 1'b0;
  assign ID_LinkAddr = ifIdOut.pcPlus4 + 32'd4;
`else
  assign ID_EX_Flush = BranchTaken;
  assign ID_LinkAddr = ifIdOut.pcPlus4;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_if_fetch_stage;

   logic        clk;
   logic        reset;
   logic [31:0] Instruction;
   logic        Stall;
   logic [1:0]  PCSrc;
   logic [31:0] JrTarget;
   logic        BranchTaken;
   logic [31:0] BranchTarget;
   logic [31:0] InstAddr;
   logic [31:0] ID_Instruction;
   logic [31:0] ID_PC_plus4;
   logic [31:0] ID_LinkAddr;
   logic        ID_Valid;
   logic        ID_EX_Flush;

   int assertCount = 0;
   int failCount   = 0;

   // Architectural view of the fetch stage as the model sees it.
   logic [31:0] mPc;
   logic [31:0] mInstr;
   logic [31:0] mPc4;
   logic        mValid;
   logic        mPc4Known;

`ifdef DELAY_SLOT_EN
   localparam bit DS = 1'b1;
`else
   localparam bit DS = 1'b0;
`endif

   if_fetch_stage dut (
      .clk           (clk),
      .reset         (reset),
      .Instruction   (Instruction),
      .Stall         (Stall),
      .PCSrc         (PCSrc),
      .JrTarget      (JrTarget),
      .BranchTaken   (BranchTaken),
      .BranchTarget  (BranchTarget),
      .InstAddr      (InstAddr),
      .ID_Instruction(ID_Instruction),
      .ID_PC_plus4   (ID_PC_plus4),
      .ID_LinkAddr   (ID_LinkAddr),
      .ID_Valid      (ID_Valid),
      .ID_EX_Flush   (ID_EX_Flush)
   );

   // Free-running 10-time-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Advance the model by one clock edge using the fetch-stage rules.
   task automatic modelStep(input logic r, input logic st, input logic [1:0] src,
                            input logic [31:0] jr, input logic bt, input logic [31:0] btg,
                            input logic [31:0] ins);
      logic [31:0] target;
      bit          redirect;
      if (r) begin
         mPc = 32'h0; mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0; mPc4Known = 1'b1;
      end else if (bt) begin
         mPc = btg; mInstr = 32'h0; mValid = 1'b0; mPc4Known = 1'b0;
      end else if (!st) begin
         redirect = mValid && (src == 2'd1 || src == 2'd2);
         if (src == 2'd1)
            target = (mPc4 & 32'hF000_0000) | ((mInstr & 32'h03FF_FFFF) * 4);
         else
            target = jr;
         if (redirect && !DS) begin
            mPc = target; mInstr = 32'h0; mValid = 1'b0; mPc4Known = 1'b0;
         end else begin
            mInstr = ins; mPc4 = mPc + 4; mValid = 1'b1; mPc4Known = 1'b1;
            mPc = redirect ? target : mPc + 4;
         end
      end
   endtask

   // Compare the registered state against the model.
   task automatic checkState();
      checkOutput("InstAddr", InstAddr, mPc);
      checkOutput("ID_Valid", {31'b0, ID_Valid}, {31'b0, mValid});
      checkOutput("ID_Instruction", ID_Instruction, mInstr);
      if (mPc4Known) begin
         checkOutput("ID_PC_plus4", ID_PC_plus4, mPc4);
         if (mValid)
            checkOutput("ID_LinkAddr", ID_LinkAddr, DS ? mPc4 + 4 : mPc4);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, check the combinational
   // flush output, let the edge happen, then check the new state.
   task automatic applyStimulus(input logic r, input logic st, input logic [1:0] src,
                                input logic [31:0] jr, input logic bt, input logic [31:0] btg,
                                input logic [31:0] ins);
      @(negedge clk);
      reset = r; Stall = st; PCSrc = src; JrTarget = jr;
      BranchTaken = bt; BranchTarget = btg; Instruction = ins;
      #1;
      checkOutput("ID_EX_Flush", {31'b0, ID_EX_Flush}, {31'b0, (DS ? 1'b0 : bt)});
      @(posedge clk);
      modelStep(r, st, src, jr, bt, btg, ins);
      #2;
      checkState();
   endtask

   initial begin
      reset = 1'b0; Stall = 1'b0; PCSrc = 2'b00; JrTarget = '0;
      BranchTaken = 1'b0; BranchTarget = '0; Instruction = '0;
      mPc = '0; mInstr = '0; mPc4 = '0; mValid = 1'b0; mPc4Known = 1'b0;

      // Reset, then sequential fetch from 0 through 0x10.
      applyStimulus(1, 0, 2'd0, 0, 0, 0, 32'h0);
      checkOutput("resetAddr", InstAddr, 32'h0);
      for (int i = 0; i < 4; i++)
         applyStimulus(0, 0, 2'd0, 0, 0, 0, 32'h2000_0000 + i);
      checkOutput("seqAddr", InstAddr, 32'h10);

      // Fetch "j 0x100" at 0x10, then let ID redirect to 0x400.
      applyStimulus(0, 0, 2'd0, 0, 0, 0, 32'h0800_0100);
      applyStimulus(0, 0, 2'd1, 0, 0, 0, 32'hAAAA_0014);
      checkOutput("jumpAddr", InstAddr, 32'h400);

      // jr held in ID through a two-cycle stall, then redirect to 0x80.
      applyStimulus(0, 0, 2'd0, 0, 0, 0, 32'h0320_0008);
      applyStimulus(0, 1, 2'd2, 32'h80, 0, 0, 32'h1111_1111);
      applyStimulus(0, 1, 2'd2, 32'h80, 0, 0, 32'h2222_2222);
      applyStimulus(0, 0, 2'd2, 32'h80, 0, 0, 32'h3333_3333);
      checkOutput("jrAddr", InstAddr, 32'h80);

      // Branch beats both a stall and a pending jump.
      applyStimulus(0, 0, 2'd0, 0, 0, 0, 32'h0800_0040);
      applyStimulus(0, 1, 2'd1, 0, 1, 32'h200, 32'h4444_4444);
      checkOutput("branchAddr", InstAddr, 32'h200);

      // PC+4 wraps at the top of the address space.
      applyStimulus(0, 0, 2'd0, 0, 1, 32'hFFFF_FFFC, 32'h5555_5555);
      applyStimulus(0, 0, 2'd0, 0, 0, 0, 32'h6666_6666);
      checkOutput("wrapAddr", InstAddr, 32'h0);

      // Reset mid-run from PC 0x40 with a valid IF/ID entry.
      applyStimulus(0, 0, 2'd0, 0, 1, 32'h3C, 32'h0);
      applyStimulus(0, 0, 2'd0, 0, 0, 0, 32'h7777_7777);
      checkOutput("preResetAddr", InstAddr, 32'h40);
      applyStimulus(1, 0, 2'd1, 32'h123, 1, 32'h999, 32'h8888_8888);
      applyStimulus(0, 0, 2'd0, 0, 0, 0, 32'h9999_9999);
      checkOutput("resumeAddr", InstAddr, 32'h4);

      // Randomized traffic with occasional resets, stalls and redirects.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
                       2'($urandom_range(0, 3)), $urandom,
                       ($urandom_range(0, 5) == 0),
                       ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : $urandom,
                       $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
